// File: rtl/led_drv_pkg.sv
// rtl/led_drv_pkg.sv - shared constants for the LED PWM driver
package led_drv_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DUTY   = 2'd1;
    localparam logic [1:0] ADDR_BLINK  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [1:0]  CTRL_RST  = 2'h1;
    localparam logic [7:0]  DUTY_RST  = 8'hFF;
    localparam logic [15:0] BLINK_RST = 16'h0040;

    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_BLINK_EN_BIT = 1;

    function automatic logic [31:0] status_word(input logic       blink_phase,
                                                input logic [7:0] pwm_cnt,
                                                input logic [7:0] duty_active);
        return {8'h00, duty_active, pwm_cnt, 7'b0, blink_phase};
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - PWM step prescaler, one-cycle tick every TICK_DIV clocks
module led_tick_gen #(
    parameter int TICK_DIV = 500
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] DIV_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_MAX) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_MAX);

endmodule

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - LED pad driver with PWM brightness, blink and polarity
module led_pwm_driver
    import led_drv_pkg::*;
#(
    parameter int TICK_DIV   = 500,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  led_value,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  led_pad
);

    localparam logic [7:0] PAD_RST = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic        tick;
    logic [1:0]  ctrl;
    logic [7:0]  duty;
    logic [7:0]  duty_active;
    logic [7:0]  pwm_cnt;
    logic [15:0] blink_period;
    logic [15:0] blink_cnt;
    logic        blink_phase;
    logic        wr_en;
    logic        wr_blink;
    logic        frame_end;
    logic        pwm_on;
    logic [7:0]  lit;
    logic        unused_wdata;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign wr_en        = chipselect && !write_n;
    assign wr_blink     = wr_en && (address == ADDR_BLINK);
    assign frame_end    = tick && (pwm_cnt == 8'hFF);
    assign pwm_on       = (pwm_cnt < duty_active) || (duty_active == 8'hFF);
    assign lit          = led_value & {8{ctrl[CTRL_ENABLE_BIT] & pwm_on &
                                         (~ctrl[CTRL_BLINK_EN_BIT] | blink_phase)}};
    assign unused_wdata = ^writedata[31:16];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl <= CTRL_RST;
            duty <= DUTY_RST;
        end else if (wr_en) begin
            if (address == ADDR_CTRL) ctrl <= writedata[1:0];
            if (address == ADDR_DUTY) duty <= writedata[7:0];
        end
    end

    // duty_active only changes at a frame boundary so every frame is whole
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt     <= '0;
            duty_active <= DUTY_RST;
        end else begin
            if (tick) pwm_cnt <= pwm_cnt + 8'd1;
            if (frame_end) duty_active <= duty;
        end
    end

    // a period write restarts the blink cycle and takes precedence over a wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_period <= BLINK_RST;
            blink_cnt    <= '0;
            blink_phase  <= 1'b1;
        end else if (wr_blink) begin
            blink_period <= writedata[15:0];
            blink_cnt    <= '0;
            blink_phase  <= 1'b1;
        end else if (frame_end) begin
            if (blink_period == 16'd0) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (blink_cnt == blink_period - 16'd1) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_pad <= PAD_RST;
        end else begin
            led_pad <= (ACTIVE_LOW != 0) ? ~lit : lit;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata = {30'b0, ctrl};
            ADDR_DUTY:   readdata = {24'b0, duty};
            ADDR_BLINK:  readdata = {16'b0, blink_period};
            ADDR_STATUS: readdata = status_word(blink_phase, pwm_cnt, duty_active);
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - self-checking bench for led_pwm_driver, TICK_DIV=4, ACTIVE_LOW=1
module tb_led_pwm_driver;

    logic        clk;
    logic        reset_n;
    logic [7:0]  led_value;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  led_pad;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    // expected-behaviour state: m_k = edges since reset release, m_f = frames since last period write
    int         m_k;
    int         m_f;
    logic [1:0] m_ctrl;
    int         m_duty;
    int         m_da;
    int         m_period;

    led_pwm_driver #(.TICK_DIV(4), .ACTIVE_LOW(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .led_value  (led_value),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_pad    (led_pad)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (led_pad !== e) begin
                errors++;
                $display("FAIL led_pad edge=%0d got=%02h exp=%02h", m_k, led_pad, e);
            end
        end
    end

    function automatic logic phase_now();
        if (m_period == 0) return 1'b1;
        return ((m_f / m_period) % 2) == 0;
    endfunction

    task automatic model_reset();
        m_k = 0; m_f = 0; m_ctrl = 2'b01; m_duty = 255; m_da = 255; m_period = 64;
    endtask

    // one clock: capture driven inputs, predict the pad after the edge, then apply the edge's effects
    task automatic step();
        logic       wr;
        logic [1:0] a;
        logic [31:0] d;
        logic [7:0] lv;
        logic [7:0] lit;
        int         pwm_b;
        logic       on;
        wr = chipselect && !write_n; a = address; d = writedata; lv = led_value;
        @(posedge clk);
        #1;
        pwm_b = (m_k / 4) % 256;
        on = (pwm_b < m_da) || (m_da == 255);
        lit = (m_ctrl[0] && on && (!m_ctrl[1] || phase_now())) ? lv : 8'h00;
        exp_q.push_back(~lit);
        if (((m_k + 1) % 1024) == 0) begin
            m_da = m_duty;
            m_f++;
        end
        if (wr) begin
            case (a)
                2'd0: m_ctrl = d[1:0];
                2'd1: m_duty = int'(d[7:0]);
                2'd2: begin m_period = int'(d[15:0]); m_f = 0; end
                default: ;
            endcase
        end
        m_k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic read_check(input logic [1:0] a, input logic [31:0] e, input string name);
        address = a;
        #1;
        checks++;
        if (readdata !== e) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", name, readdata, e);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (led_pad !== 8'hFF) begin errors++; $display("FAIL reset_pad got=%02h exp=ff", led_pad); end
        read_check(2'd0, 32'h1, "reset_ctrl");
        read_check(2'd1, 32'hFF, "reset_duty");
        read_check(2'd2, 32'h40, "reset_blink");
        read_check(2'd3, 32'h00FF0001, "reset_status");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        led_value = 8'h00;
        run(10);
    endtask

    task automatic test_static();
        led_value = 8'hA5;
        step();
        checks++;
        if (led_pad !== 8'h5A) begin errors++; $display("FAIL static_a5 got=%02h exp=5a", led_pad); end
        run(20);
    endtask

    task automatic test_pwm();
        int lows;
        led_value = 8'h01;
        for (int i = 0; i < 2048 && (m_k % 1024) != 500; i++) step();
        bus_write(2'd1, 32'h40);
        read_check(2'd3, {8'h00, 8'hFF, 8'((m_k / 4) % 256), 7'b0, phase_now()}, "duty_pending");
        for (int i = 0; i < 2048 && (m_k % 1024) != 0; i++) step();
        read_check(2'd3, {8'h00, 8'h40, 8'h00, 7'b0, phase_now()}, "duty_applied");
        lows = 0;
        for (int i = 0; i < 1024; i++) begin
            step();
            if (led_pad[0] === 1'b0) lows++;
        end
        checks++;
        if (lows != 256) begin errors++; $display("FAIL duty40_low_clks got=%0d exp=256", lows); end
        bus_write(2'd1, 32'h00);
        for (int i = 0; i < 2048 && (m_k % 1024) != 0; i++) step();
        lows = 0;
        for (int i = 0; i < 1024; i++) begin
            step();
            if (led_pad[0] === 1'b0) lows++;
        end
        checks++;
        if (lows != 0) begin errors++; $display("FAIL duty00_low_clks got=%0d exp=0", lows); end
    endtask

    task automatic test_blink();
        logic [7:0] prev;
        int t[3];
        int nt;
        led_value = 8'hFF;
        bus_write(2'd1, 32'hFF);
        bus_write(2'd2, 32'h2);
        bus_write(2'd0, 32'h3);
        for (int i = 0; i < 2048 && (m_k % 1024) != 0; i++) step();
        run(2);
        address = 2'd3;
        prev = led_pad;
        nt = 0;
        for (int i = 0; i < 7000 && nt < 3; i++) begin
            step();
            if (led_pad !== prev) begin
                t[nt] = m_k;
                nt++;
                prev = led_pad;
                checks++;
                if (readdata[0] !== phase_now()) begin
                    errors++;
                    $display("FAIL status_phase got=%0b exp=%0b", readdata[0], phase_now());
                end
            end
        end
        checks++;
        if (nt != 3) begin
            errors++;
            $display("FAIL blink_transitions got=%0d exp=3", nt);
        end else begin
            checks++;
            if (t[1] - t[0] != 2048 || t[2] - t[1] != 2048) begin
                errors++;
                $display("FAIL blink_half_period got=%0d,%0d exp=2048", t[1] - t[0], t[2] - t[1]);
            end
        end
    endtask

    task automatic test_wrap_write();
        int i;
        i = 0;
        while (i < 5000 && !(((m_k + 1) % 1024) == 0 && ((m_f + 1) % m_period) == 0 && phase_now())) begin
            step();
            i++;
        end
        checks++;
        if (i >= 5000) begin errors++; $display("FAIL wrap_align got=timeout exp=aligned"); end
        bus_write(2'd2, 32'h2);
        read_check(2'd3, {8'h00, 8'hFF, 8'h00, 7'b0, 1'b1}, "wrap_write_phase");
        run(2047);
        read_check(2'd3, {8'h00, 8'hFF, 8'hFF, 7'b0, 1'b1}, "wrap_phase_held");
        step();
        read_check(2'd3, {8'h00, 8'hFF, 8'h00, 7'b0, 1'b0}, "wrap_phase_toggle");
    endtask

    task automatic test_ctrl_status();
        run(2048);
        run(2);
        checks++;
        if (led_pad !== 8'h00) begin errors++; $display("FAIL pre_disable got=%02h exp=00", led_pad); end
        bus_write(2'd0, 32'h0);
        checks++;
        if (led_pad !== 8'h00) begin errors++; $display("FAIL disable_edge got=%02h exp=00", led_pad); end
        step();
        checks++;
        if (led_pad !== 8'hFF) begin errors++; $display("FAIL disable_next got=%02h exp=ff", led_pad); end
        led_value = 8'h3C;
        run(3);
        checks++;
        if (led_pad !== 8'hFF) begin errors++; $display("FAIL disabled_3c got=%02h exp=ff", led_pad); end
        run(7);
        read_check(2'd3, {8'h00, 8'hFF, 8'((m_k / 4) % 256), 7'b0, phase_now()}, "status_pwm");
        bus_write(2'd3, 32'hFFFF_FFFF);
        read_check(2'd0, 32'h0, "ro_ctrl");
        read_check(2'd1, 32'hFF, "ro_duty");
        read_check(2'd2, 32'h2, "ro_blink");
        read_check(2'd3, {8'h00, 8'hFF, 8'((m_k / 4) % 256), 7'b0, phase_now()}, "ro_status");
    endtask

    task automatic test_reset_mid();
        led_value = 8'hFF;
        bus_write(2'd0, 32'h3);
        for (int i = 0; i < 5000 && !(phase_now() && (m_k % 1024) == 512); i++) step();
        step();
        checks++;
        if (led_pad !== 8'h00) begin errors++; $display("FAIL mid_blink_on got=%02h exp=00", led_pad); end
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (led_pad !== 8'hFF) begin errors++; $display("FAIL async_reset got=%02h exp=ff", led_pad); end
        read_check(2'd0, 32'h1, "rst2_ctrl");
        read_check(2'd1, 32'hFF, "rst2_duty");
        read_check(2'd2, 32'h40, "rst2_blink");
        read_check(2'd3, 32'h00FF0001, "rst2_status");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        run(20);
    endtask

    initial begin
        reset_n = 1'b0; led_value = 8'h00; address = 2'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
        model_reset();
        test_reset();
        test_static();
        test_pwm();
        test_blink();
        test_wrap_write();
        test_ctrl_status();
        test_reset_mid();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pwm_driver.md
# led_pwm_driver

Downstream stage of the LED PIO. Takes the PIO's 8-bit `out_port` value and drives the board LED pads with:
- global PWM brightness;
- optional blinking;
- configurable pad polarity.

It is configured through its own small Avalon-MM slave (4 words) on the same bus and clock as the PIO.

## Interface
Parameters:
- `TICK_DIV`, 500 — clk cycles per PWM step; legal range 2..65535.
- `ACTIVE_LOW`, 1 — 1: pad driven 0 lights the LED; 0: pad driven 1 lights it.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `led_value`  in  8  LED request from the PIO `out_port`; bit i = 1 requests LED i lit. Same clock domain, no synchroniser.
- `address`  in  2  word address of the CSR slave.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  combinational read data; zero-latency read, same as the PIO.
- `led_pad`  out  8  registered LED pad drive.

## Operation
Register map:
- 0 CTRL (R/W): bit0 `enable`, bit1 `blink_en`. Reset value 0x1.
- 1 DUTY (R/W): bits[7:0] brightness. Reset value 0xFF.
- 2 BLINK_PERIOD (R/W): bits[15:0], counted in PWM frames. Reset value 0x0040.
- 3 STATUS (RO): bit0 `blink_phase`, bits[15:8] `pwm_cnt`, bits[23:16] `duty_active`.

Register access rules:
- Unused bits read 0.
- Writes to STATUS are ignored.
- A write occurs when `chipselect && !write_n`; the register updates on that clk edge.

Tick prescaler:
- `div_cnt` counts 0..TICK_DIV-1 and wraps.
- `tick` is a 1-cycle pulse when `div_cnt == TICK_DIV-1`.

PWM:
- The 8-bit `pwm_cnt` increments on `tick` and wraps 255→0.
- `frame_end` = `tick && pwm_cnt == 255`.
- `pwm_on` = `(pwm_cnt < duty_active) || (duty_active == 0xFF)`. DUTY 0x00 gives fully off; 0xFF gives fully on.
- `duty_active` loads from DUTY only on `frame_end`, so no partial frames are produced. The reset value of `duty_active` is 0xFF.

Blink:
- The 16-bit `blink_cnt` advances on `frame_end`.
- When `blink_cnt == BLINK_PERIOD-1`, it clears and toggles `blink_phase`.
- BLINK_PERIOD = 0 freezes `blink_phase` at 1.
- Any write to BLINK_PERIOD clears `blink_cnt` and sets `blink_phase` = 1 on the same edge.
- If a period write coincides with a wrap, the write wins.

Output:
- `lit[i]` = `enable & led_value[i] & pwm_on & (!blink_en | blink_phase)`.
- `led_pad` <= `ACTIVE_LOW ? ~lit : lit` (registered).

Reset:
- All counters 0, `blink_phase` 1, registers at the reset values above.
- `led_pad` = 0xFF when ACTIVE_LOW=1, 0x00 when ACTIVE_LOW=0.
- Reset asserted mid-frame forces this state immediately (asynchronous).

## Timing
- `led_value`/CTRL change to `led_pad` change: 1 clk, i.e. a register write at edge N is visible on the pad after edge N+1.
- DUTY write to effect: at the next `frame_end` edge. Worst case 256·TICK_DIV clks.
- Frame length: 256·TICK_DIV clks. Blink half-period: BLINK_PERIOD frames.
- `readdata` is combinational from `address`; no wait states, no read side effects.
- Simultaneous DUTY write and `frame_end`: `duty_active` takes the old DUTY value; the new value applies at the following frame.

## Structure
- Package `led_drv_pkg`:
  - address constants `ADDR_CTRL`/`ADDR_DUTY`/`ADDR_BLINK`/`ADDR_STATUS`;
  - reset constants `CTRL_RST`=0x1, `DUTY_RST`=0xFF, `BLINK_RST`=0x0040;
  - CTRL bit indices.
- Sub-module `led_tick_gen`: prescaler with parameter TICK_DIV; outputs `tick`.
- The top level holds the CSRs, PWM and blink counters, and the output register.

## Test plan
All scenarios use TICK_DIV=4, ACTIVE_LOW=1.
- Reset, then release with `led_value`=0x00: `led_pad`=0xFF. Set `led_value`=0xA5: `led_pad`=0x5A one clk later and held steady (duty 0xFF).
- Write DUTY=0x40 mid-frame, `led_value`=0x01: pad bit0 unchanged until the next `frame_end`. Afterwards, per 1024-clk frame, bit0 is low for exactly 256 clks then high for 768. DUTY=0x00 gives bit0 constantly high.
- Write BLINK_PERIOD=2 and CTRL=0x3, `led_value`=0xFF, DUTY=0xFF: `led_pad` alternates 0x00/0xFF every 2048 clks. STATUS bit0 tracks the phase.
- Write BLINK_PERIOD on the same cycle as a blink wrap: `blink_cnt`=0 and `blink_phase`=1 after the edge, with no toggle.
- Write CTRL=0x0: `led_pad`=0xFF one clk later regardless of `led_value`. Read address 3 returns `pwm_cnt` in bits[15:8]. A write to address 3 changes nothing.
- Assert `reset_n` mid-blink with `led_pad`=0x00: `led_pad`=0xFF asynchronously. All registers read back reset values: 0x1, 0xFF, 0x0040.
